// File: rtl/fft_result_serializer_if.sv
// fft_result_serializer_if
//   Bundles the FFT burst input side and the complex-sample output stream
//   of fft_result_serializer.
//   fftr_valid/ffti_valid : burst qualifiers (real / imaginary half)
//   fft_d                 : LANES lane words, lane n = frame element n
//   out_valid/out_ready   : output stream handshake
//   out_re/out_im/out_idx : complex sample and its global point index
//   done/err              : sticky completion / protocol-overflow flags
//   modport master : producer + downstream side (drives bursts, out_ready)
//   modport slave  : the serializer
interface fft_result_serializer_if #(
  parameter int DW       = 16,
  parameter int LANES    = 16,
  parameter int N_POINTS = 1024
);
  localparam int IW = $clog2(N_POINTS);

  logic                      fftr_valid;
  logic                      ffti_valid;
  logic [LANES-1:0][DW-1:0]  fft_d;
  logic                      out_valid;
  logic                      out_ready;
  logic [DW-1:0]             out_re;
  logic [DW-1:0]             out_im;
  logic [IW-1:0]             out_idx;
  logic                      done;
  logic                      err;

  modport master (
    output fftr_valid, ffti_valid, fft_d, out_ready,
    input  out_valid, out_re, out_im, out_idx, done, err
  );

  modport slave (
    input  fftr_valid, ffti_valid, fft_d, out_ready,
    output out_valid, out_re, out_im, out_idx, done, err
  );
endinterface

// File: rtl/fft_result_serializer.sv
// fft_result_serializer
//   Captures LANES-wide real and imaginary bursts from the FFT core into a
//   ping-pong pair of banks, pairs them per frame and streams one complex
//   sample per valid/ready transfer until N_POINTS samples are out (done).
//   The producer cannot be stalled: a burst arriving while both banks are
//   occupied, or a repeated half, is dropped and flags err.
//   Ports:
//     clk : clock, all logic on posedge
//     rst : synchronous active-high reset
//     bus : fft_result_serializer_if.slave (bursts in, sample stream out)
//   Build option:
//     BITREV_EN : drain each frame in bit-reversed lane order; out_idx then
//                 reports frame_base + bitrev(lane).

// One lane of both banks: real and imaginary word per bank.
module fft_lane_buf #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we_re,
  input  logic          we_im,
  input  logic          wsel,
  input  logic          rsel,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] re,
  output logic [DW-1:0] im
);
  logic [1:0][DW-1:0] re_q, im_q;

  // Data words need no reset: the bank flags decide what is valid.
  always_ff @(posedge clk) begin
    if (we_re) re_q[wsel] <= d;
    if (we_im) im_q[wsel] <= d;
  end

  assign re = re_q[rsel];
  assign im = im_q[rsel];
endmodule

module fft_result_serializer #(
  parameter int DW       = 16,
  parameter int LANES    = 16,
  parameter int N_POINTS = 1024
) (
  input logic                   clk,
  input logic                   rst,
  fft_result_serializer_if.slave bus
);
  localparam int LW = $clog2(LANES);
  localparam int IW = $clog2(N_POINTS);

  logic          wr_bank, rd_bank;
  logic [1:0]    has_re, has_im, full;
  logic [IW-1:0] cnt;        // transfers so far; low LW bits are the lane
  logic          done_q, err_q;

  logic          cap_re, cap_im, nre, nim, cmpl, drop, xfer, last_lane;
  logic [LW-1:0] lane, rd_lane;
  logic [LANES-1:0][DW-1:0] lane_re, lane_im;

  // Capture decisions use the registered flags of the write bank.
  assign cap_re = bus.fftr_valid && !done_q && !full[wr_bank] && !has_re[wr_bank];
  assign cap_im = bus.ffti_valid && !done_q && !full[wr_bank] && !has_im[wr_bank];
  assign nre    = has_re[wr_bank] | cap_re;
  assign nim    = has_im[wr_bank] | cap_im;
  assign cmpl   = nre && nim;
  assign drop   = !done_q &&
                  (((bus.fftr_valid || bus.ffti_valid) && full[wr_bank]) ||
                   (bus.fftr_valid && has_re[wr_bank]) ||
                   (bus.ffti_valid && has_im[wr_bank]));

  assign lane      = cnt[LW-1:0];
  assign last_lane = (lane == LW'(LANES-1));
  assign xfer      = bus.out_valid && bus.out_ready;

`ifdef BITREV_EN
  function automatic logic [LW-1:0] bitrev(input logic [LW-1:0] v);
    logic [LW-1:0] r;
    for (int i = 0; i < LW; i++) r[i] = v[LW-1-i];
    return r;
  endfunction
  assign rd_lane = bitrev(lane);
`else
  assign rd_lane = lane;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fft_lane_buf #(.DW(DW)) u_lane (
      .clk   (clk),
      .we_re (cap_re),
      .we_im (cap_im),
      .wsel  (wr_bank),
      .rsel  (rd_bank),
      .d     (bus.fft_d[g]),
      .re    (lane_re[g]),
      .im    (lane_im[g])
    );
  end

  // Data is gated so the stream reads zero whenever nothing is offered.
  assign bus.out_valid = full[rd_bank] && !done_q;
  assign bus.out_re    = bus.out_valid ? lane_re[rd_lane] : '0;
  assign bus.out_im    = bus.out_valid ? lane_im[rd_lane] : '0;
  assign bus.out_idx   = {cnt[IW-1:LW], rd_lane};
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      has_re  <= '0;
      has_im  <= '0;
      full    <= '0;
      cnt     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Write side. A bank being set full and one being freed on the same
      // edge are always different banks, so the two updates never collide.
      if (cmpl) begin
        full[wr_bank]   <= 1'b1;
        has_re[wr_bank] <= 1'b0;
        has_im[wr_bank] <= 1'b0;
        wr_bank         <= ~wr_bank;
      end else begin
        has_re[wr_bank] <= nre;
        has_im[wr_bank] <= nim;
      end

      // Read side.
      if (xfer) begin
        cnt <= cnt + IW'(1);
        if (cnt == IW'(N_POINTS-1)) done_q <= 1'b1;
        if (last_lane) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end

      if (drop) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fft_result_serializer.sv
// tb_fft_result_serializer
//   Randomized and directed stimulus against a transaction-level model:
//   completed frames sit in a queue (at most two), a partial frame collects
//   halves, and each transfer pops the next sample in drain order.
module tb_fft_result_serializer;
  localparam int DW = 16, LANES = 16, NP = 1024;

  typedef logic [LANES-1:0][DW-1:0] vec_t;
  typedef struct packed { vec_t re; vec_t im; } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_result_serializer_if #(.DW(DW), .LANES(LANES), .N_POINTS(NP)) bus ();

  fft_result_serializer #(.DW(DW), .LANES(LANES), .N_POINTS(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  frame_t q[$];
  vec_t   p_re, p_im;
  bit     p_hr, p_hi, m_done, m_err, chk_zero, armed;
  int     m_cnt;
  int     ord[LANES];

  initial begin
`ifdef BITREV_EN
    int br[LANES] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    ord = br;
`else
    for (int i = 0; i < LANES; i++) ord[i] = i;
`endif
  end

  task automatic check_outputs();
    bit exp_v;
    frame_t f;
    int l;
    if (!armed) return;
    exp_v = (q.size() > 0) && !m_done;
    chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
    if (exp_v) begin
      f = q[0];
      l = ord[m_cnt % LANES];
      chk("out_re",  32'(bus.out_re),  32'(f.re[l]));
      chk("out_im",  32'(bus.out_im),  32'(f.im[l]));
      chk("out_idx", 32'(bus.out_idx), 32'((m_cnt / LANES) * LANES + l));
    end
    if (chk_zero) begin
      chk("rst_re",  32'(bus.out_re),  32'd0);
      chk("rst_im",  32'(bus.out_im),  32'd0);
      chk("rst_idx", 32'(bus.out_idx), 32'd0);
    end
    chk("done", 32'(bus.done), 32'(m_done));
    chk("err",  32'(bus.err),  32'(m_err));
  endtask

  task automatic model_step(input bit fr, input bit fi, input vec_t d, input bit rdy, input bit r);
    int occ;
    bit xf;
    frame_t f;
    if (r) begin
      q.delete();
      p_hr = 0; p_hi = 0; m_done = 0; m_err = 0; m_cnt = 0;
      chk_zero = 1; armed = 1;
      return;
    end
    chk_zero = 0;
    occ = q.size();
    xf  = (occ > 0) && !m_done && rdy;
    if (!m_done) begin
      if ((fr || fi) && occ == 2) m_err = 1;
      else begin
        if (fr) begin
          if (p_hr) m_err = 1;
          else begin p_re = d; p_hr = 1; end
        end
        if (fi) begin
          if (p_hi) m_err = 1;
          else begin p_im = d; p_hi = 1; end
        end
      end
    end
    if (xf) begin
      m_cnt++;
      if (m_cnt == NP) m_done = 1;
      if (m_cnt % LANES == 0) void'(q.pop_front());
    end
    if (p_hr && p_hi) begin
      f.re = p_re; f.im = p_im;
      q.push_back(f);
      p_hr = 0; p_hi = 0;
    end
  endtask

  // One clock: drive, check at negedge, advance the model, cross the edge.
  task automatic cycle(input bit fr, input bit fi, input vec_t d, input bit rdy, input bit r);
    bus.fftr_valid = fr;
    bus.ffti_valid = fi;
    bus.fft_d      = d;
    bus.out_ready  = rdy;
    rst            = r;
    @(negedge clk);
    check_outputs();
    model_step(fr, fi, d, rdy, r);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t rnd_d();
    vec_t v;
    for (int i = 0; i < LANES; i++) v[i] = DW'($urandom);
    return v;
  endfunction

  function automatic vec_t seq_d(input logic [DW-1:0] base);
    vec_t v;
    for (int i = 0; i < LANES; i++) v[i] = base + DW'(i);
    return v;
  endfunction

  task automatic do_reset();
    cycle(0, 0, rnd_d(), 0, 1);
    cycle(0, 0, rnd_d(), 0, 1);
  endtask

  task automatic idle(input int n, input int rmode);
    for (int i = 0; i < n; i++)
      cycle(0, 0, rnd_d(), (rmode == 1) ? 1'b1 : (rmode == 2) ? (i % 3 == 0) : 1'b0, 0);
  endtask

  // mode 0: both halves together, 1: real then imag, 2: imag then real.
  // Returns the number of cycles used.
  task automatic send_frame(input int mode, input vec_t re, input vec_t im, input bit rdy, output int used);
    case (mode)
      0: begin
        cycle(1, 1, re, rdy, 0);  // same word drives both halves
        used = 1;
      end
      1: begin cycle(1, 0, re, rdy, 0); cycle(0, 1, im, rdy, 0); used = 2; end
      default: begin cycle(0, 1, im, rdy, 0); cycle(1, 0, re, rdy, 0); used = 2; end
    endcase
  endtask

  initial begin
    int u;
    vec_t v;
    bus.fftr_valid = 0; bus.ffti_valid = 0; bus.fft_d = '0; bus.out_ready = 0;

    // Directed first frame
    do_reset();
    send_frame(1, seq_d(16'h0100), seq_d(16'hFF00), 1, u);
    idle(20, 1);

    // Same-cycle frame followed directly by imag-first frame
    v = rnd_d();
    send_frame(0, v, v, 1, u);
    send_frame(2, rnd_d(), rnd_d(), 1, u);
    idle(40, 1);

    // Backpressure with ready pattern 1,0,0
    send_frame(1, rnd_d(), rnd_d(), 0, u);
    idle(60, 2);

    // Three frames while stalled: third dropped
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(1, rnd_d(), rnd_d(), 0, u);
    chk("overflow_err", 32'(bus.err), 32'd1);
    idle(40, 1);

    // Duplicate real half
    do_reset();
    cycle(1, 0, seq_d(16'h1200), 1, 0);
    cycle(1, 0, seq_d(16'h3400), 1, 0);
    cycle(0, 1, seq_d(16'h5600), 1, 0);
    idle(20, 1);

    // Reset while lane 5 is presented, then a fresh frame
    do_reset();
    send_frame(0, rnd_d(), rnd_d(), 1, u);
    idle(5, 1);
    cycle(0, 0, rnd_d(), 1, 1);
    send_frame(1, seq_d(16'h0000), seq_d(16'h7F00), 1, u);
    idle(20, 1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++)
      cycle(($urandom % 5) == 0, ($urandom % 5) == 0, rnd_d(), ($urandom % 4) != 0, 0);
    idle(40, 1);

    // Full run of N_POINTS samples
    do_reset();
    for (int f = 0; f < NP / LANES; f++) begin
      send_frame(int'($urandom % 3), rnd_d(), rnd_d(), 1, u);
      idle(LANES - u, 1);
    end
    idle(40, 1);
    chk("full_done", 32'(bus.done), 32'd1);
    cycle(1, 0, rnd_d(), 1, 0);
    cycle(0, 0, rnd_d(), 1, 0);
    chk("late_err", 32'(bus.err), 32'd0);
    chk("late_valid", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Whole-run watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end
endmodule
